// File: rtl/ex_stage.sv
// ex_stage: MIPS EX stage - ID/EX register, operand select, 12-op ALU, HI/LO and 32-step divider; define EX_MULT_EN for MULT/MULTU
module ex_stage #(
    parameter int STALL_W = 6,
    parameter int DIV_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic [158:0]       id_to_ex_bus,
    output logic [75:0]        ex_to_mem_bus,
    output logic [37:0]        ex_to_id_bus,
    output logic               data_sram_en,
    output logic [3:0]         data_sram_wen,
    output logic [31:0]        data_sram_addr,
    output logic [31:0]        data_sram_wdata,
    output logic               stallreq_for_ex
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;
    div_state_e state_q, state_d;
    logic [158:0] idex_q, idex_d;
    logic [31:0] pc, inst, rd1, rd2, src_a, src_b, alu_res, ex_result;
    logic [11:0] alu_op;
    logic [2:0] sel1;
    logic [3:0] sel2;
    logic [15:0] imm;
    logic [5:0] fn, cnt_q, cnt_d;
    logic special, is_div, is_divu, is_mfhi, is_mflo, is_mthi, is_mtlo, is_mult, ld, div_wr, mul_we;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, quo_q, quo_d, rem_q, rem_d, den_q, den_d, div_hi, div_lo;
    logic qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d, done_q, done_d;
    logic [32:0] trial, diff;
    logic [63:0] prod;
    logic unused;
    assign unused = ^{stall[STALL_W-1:4], stall[1:0], inst[25:16]};
    // a load or a bubble both replace the instruction, so both clear the divider's done flag
    assign ld = ~(stall[2] & stall[3]);
    assign idex_d = !stall[2] ? id_to_ex_bus : !stall[3] ? '0 : idex_q;
    assign {pc, inst, alu_op, sel1, sel2} = idex_q[158:76];
    assign rd1 = idex_q[63:32];
    assign rd2 = idex_q[31:0];
    assign imm = inst[15:0];
    assign fn = inst[5:0];
    assign special = inst[31:26] == 6'h00;
    assign is_div  = special && fn == 6'h1A;
    assign is_divu = special && fn == 6'h1B;
    assign is_mfhi = special && fn == 6'h10;
    assign is_mflo = special && fn == 6'h12;
    assign is_mthi = special && fn == 6'h11;
    assign is_mtlo = special && fn == 6'h13;
    assign is_mult = special && fn[5:1] == 5'b01100;
    assign src_a = ({32{sel1[0]}} & rd1) | ({32{sel1[1]}} & pc) | ({32{sel1[2]}} & {27'b0, inst[10:6]});
    assign src_b = ({32{sel2[0]}} & rd2) | ({32{sel2[1]}} & {{16{imm[15]}}, imm})
                 | ({32{sel2[2]}} & 32'd8) | ({32{sel2[3]}} & {16'b0, imm});
    assign alu_res = ({32{alu_op[11]}} & (src_a + src_b))
                   | ({32{alu_op[10]}} & (src_a - src_b))
                   | ({32{alu_op[9]}}  & {31'b0, $signed(src_a) < $signed(src_b)})
                   | ({32{alu_op[8]}}  & {31'b0, src_a < src_b})
                   | ({32{alu_op[7]}}  & (src_a & src_b))
                   | ({32{alu_op[6]}}  & ~(src_a | src_b))
                   | ({32{alu_op[5]}}  & (src_a | src_b))
                   | ({32{alu_op[4]}}  & (src_a ^ src_b))
                   | ({32{alu_op[3]}}  & (src_b << src_a[4:0]))
                   | ({32{alu_op[2]}}  & (src_b >> src_a[4:0]))
                   | ({32{alu_op[1]}}  & 32'($signed(src_b) >>> src_a[4:0]))
                   | ({32{alu_op[0]}}  & {src_b[15:0], 16'b0});
    assign ex_result = is_mfhi ? hi_q : is_mflo ? lo_q : is_mult ? '0 : alu_res;
    assign ex_to_mem_bus = {pc, idex_q[75:71], idex_q[64], idex_q[70:65], ex_result};
    assign ex_to_id_bus = {idex_q[70:65], ex_result};
    assign data_sram_en = idex_q[75];
    assign data_sram_wen = idex_q[74:71];
    assign data_sram_addr = ex_result;
    assign data_sram_wdata = rd2;
`ifdef EX_MULT_EN
    assign mul_we = is_mult;
    assign prod = {{32{~fn[0] & rd1[31]}}, rd1} * {{32{~fn[0] & rd2[31]}}, rd2};
`else
    assign mul_we = 1'b0;
    assign prod = '0;
`endif
    // restoring step: bring the next dividend bit into the partial remainder and try subtracting
    assign trial = {rem_q, quo_q[31]};
    assign diff = trial - {1'b0, den_q};
    assign div_lo = dz_q ? '1 : qneg_q ? -quo_q : quo_q;
    assign div_hi = rneg_q ? -rem_q : rem_q;
    assign hi_d = div_wr ? div_hi : stall[3] ? hi_q : mul_we ? prod[63:32] : is_mthi ? rd1 : hi_q;
    assign lo_d = div_wr ? div_lo : stall[3] ? lo_q : mul_we ? prod[31:0] : is_mtlo ? rd1 : lo_q;
    assign done_d = ld ? 1'b0 : div_wr ? 1'b1 : done_q;
    // divider FSM: latch magnitudes in IDLE, 32 shift-subtract steps in BUSY, commit HI/LO in DONE
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        quo_d = quo_q;
        rem_d = rem_q;
        den_d = den_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        dz_d = dz_q;
        div_wr = 1'b0;
        stallreq_for_ex = 1'b0;
        case (state_q)
            IDLE: if ((is_div || is_divu) && !done_q) begin
                stallreq_for_ex = 1'b1;
                state_d = BUSY;
                cnt_d = '0;
                rem_d = '0;
                quo_d = (is_div && rd1[31]) ? -rd1 : rd1;
                den_d = (is_div && rd2[31]) ? -rd2 : rd2;
                qneg_d = is_div && (rd1[31] ^ rd2[31]);
                rneg_d = is_div && rd1[31];
                dz_d = rd2 == '0;
            end
            BUSY: begin
                stallreq_for_ex = 1'b1;
                quo_d = {quo_q[30:0], ~diff[32]};
                rem_d = diff[32] ? trial[31:0] : diff[31:0];
                cnt_d = cnt_q + 6'd1;
                state_d = cnt_q == 6'(DIV_W - 1) ? DONE : BUSY;
            end
            DONE: begin
                div_wr = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // pipeline register, HI/LO and divider state
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q <= '0;
            state_q <= IDLE;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            den_q <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dz_q <= 1'b0;
            done_q <= 1'b0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            idex_q <= idex_d;
            state_q <= state_d;
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            den_q <= den_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            dz_q <= dz_d;
            done_q <= done_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed bench for ex_stage with a spec-level model checked every cycle
module tb_ex_stage;
    localparam logic [31:0] PC0 = 32'hBFC0_0100;
    logic clk = 1'b0, rst = 1'b1;
    logic [5:0] stall = '0;
    logic [158:0] id_bus = '0;
    logic [75:0] mem_bus;
    logic [37:0] id_fwd;
    logic sen, sreq;
    logic [3:0] swen;
    logic [31:0] saddr, swdata;
    int n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
    ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_bus),
        .ex_to_mem_bus(mem_bus), .ex_to_id_bus(id_fwd),
        .data_sram_en(sen), .data_sram_wen(swen), .data_sram_addr(saddr),
        .data_sram_wdata(swdata), .stallreq_for_ex(sreq)
    );
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
                                        input logic [2:0] s1, input logic [3:0] s2, input logic ren,
                                        input logic [3:0] wen, input logic we, input logic [4:0] wa,
                                        input logic [31:0] a, input logic [31:0] b);
        return {pc, inst, op, s1, s2, ren, wen, we, wa, ren & (wen == 4'h0), a, b};
    endfunction
    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction
    // spec-level model state: instruction in EX, HI, LO, and how long a DIV has been sitting in EX
    logic [158:0] m_bus = '0;
    logic [31:0] m_hi = '0, m_lo = '0;
    int m_age = 0;
    bit m_done = 1'b0, m_on = 1'b0;
    function automatic bit f_isdiv(input logic [158:0] b);
        return b[126:121] == 6'h00 && (b[100:95] == 6'h1A || b[100:95] == 6'h1B);
    endfunction
    function automatic logic [31:0] f_res(input logic [158:0] b, input logic [31:0] h, input logic [31:0] l);
        logic [31:0] inst, x, y;
        logic [15:0] imm;
        inst = b[126:95];
        imm = inst[15:0];
        if (inst[31:26] == 6'h00 && inst[5:0] == 6'h10) return h;
        if (inst[31:26] == 6'h00 && inst[5:0] == 6'h12) return l;
        if (inst[31:26] == 6'h00 && (inst[5:0] == 6'h18 || inst[5:0] == 6'h19)) return 32'h0;
        x = b[80] ? b[63:32] : b[81] ? b[158:127] : b[82] ? {27'b0, inst[10:6]} : 32'h0;
        y = b[76] ? b[31:0] : b[77] ? {{16{imm[15]}}, imm} : b[78] ? 32'd8 : b[79] ? {16'h0, imm} : 32'h0;
        case (b[94:83])
            12'h800: return x + y;
            12'h400: return x - y;
            12'h200: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            12'h100: return (x < y) ? 32'd1 : 32'd0;
            12'h080: return x & y;
            12'h040: return ~(x | y);
            12'h020: return x | y;
            12'h010: return x ^ y;
            12'h008: return y << x[4:0];
            12'h004: return y >> x[4:0];
            12'h002: return $signed(y) >>> x[4:0];
            12'h001: return {y[15:0], 16'h0};
            default: return 32'h0;
        endcase
    endfunction
    always @(posedge clk) begin
        logic [31:0] r1, r2;
        longint sp;
        if (rst) begin
            m_bus = '0; m_hi = '0; m_lo = '0; m_age = 0; m_done = 1'b0; m_on = 1'b1;
        end else begin
            r1 = m_bus[63:32];
            r2 = m_bus[31:0];
            if (f_isdiv(m_bus) && !m_done) begin
                if (m_age == 33) begin
                    m_done = 1'b1;
                    if (r2 == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = r1; end
                    else if (m_bus[95]) begin m_lo = r1 / r2; m_hi = r1 % r2; end
                    else begin m_lo = $signed(r1) / $signed(r2); m_hi = $signed(r1) % $signed(r2); end
                end else m_age++;
            end else if (!stall[3] && m_bus[126:121] == 6'h00) begin
                if (m_bus[100:95] == 6'h11) m_hi = r1;
                if (m_bus[100:95] == 6'h13) m_lo = r1;
`ifdef EX_MULT_EN
                if (m_bus[100:95] == 6'h18) begin
                    sp = longint'($signed(r1)) * longint'($signed(r2));
                    {m_hi, m_lo} = sp;
                end
                if (m_bus[100:95] == 6'h19) {m_hi, m_lo} = {32'h0, r1} * {32'h0, r2};
`endif
            end
            if (!stall[2]) begin m_bus = id_bus; m_age = 0; m_done = 1'b0; end
            else if (!stall[3]) begin m_bus = '0; m_age = 0; m_done = 1'b0; end
        end
    end
    always @(negedge clk) begin
        logic [31:0] r;
        if (m_on) begin
            r = f_res(m_bus, m_hi, m_lo);
            check("mem_bus", mem_bus, {m_bus[158:127], m_bus[75:71], m_bus[64], m_bus[70:65], r});
            check("id_bus", id_fwd, {m_bus[70:65], r});
            check("sram", {sen, swen, saddr, swdata}, {m_bus[75:71], r, m_bus[31:0]});
            check("stallreq", sreq, f_isdiv(m_bus) && !m_done && m_age < 33);
        end
    end
    task automatic tick(input logic [158:0] b, input logic [5:0] s);
        id_bus = b;
        stall = s;
        @(negedge clk);
    endtask
    task automatic run_div(input logic [158:0] b, input logic [158:0] nxt, output int n);
        n = 0;
        tick(b, 6'b0);
        for (int i = 0; i < 60 && sreq; i++) begin
            n++;
            tick(b, 6'b001111);
        end
        tick(nxt, 6'b0);
    endtask
    typedef struct packed {
        logic [11:0] op; logic [2:0] s1; logic [3:0] s2; logic [15:0] imm;
        logic [31:0] a; logic [31:0] b; logic [31:0] exp;
    } vec_t;
    vec_t vt [0:13];
    logic [158:0] mfhi, mflo;
    int n;
    initial begin
        mfhi = mk(PC0, rtype(5'd0, 5'd0, 5'd8, 6'h10), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd8, 32'h0, 32'h0);
        mflo = mk(PC0, rtype(5'd0, 5'd0, 5'd9, 6'h12), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd9, 32'h0, 32'h0);
        vt[0]  = '{12'h400, 3'b001, 4'b0001, 16'h0000, 32'd5, 32'd7, 32'hFFFF_FFFE};
        vt[1]  = '{12'h200, 3'b001, 4'b0001, 16'h0000, 32'hFFFF_FFFF, 32'd1, 32'd1};
        vt[2]  = '{12'h100, 3'b001, 4'b0001, 16'h0000, 32'hFFFF_FFFF, 32'd1, 32'd0};
        vt[3]  = '{12'h080, 3'b001, 4'b0001, 16'h0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vt[4]  = '{12'h040, 3'b001, 4'b0001, 16'h0000, 32'h0F0F_0000, 32'h0000_00F0, 32'hF0F0_FF0F};
        vt[5]  = '{12'h020, 3'b001, 4'b1000, 16'hFFFF, 32'h1234_0000, 32'h0, 32'h1234_FFFF};
        vt[6]  = '{12'h010, 3'b001, 4'b0001, 16'h0000, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
        vt[7]  = '{12'h008, 3'b100, 4'b0001, 16'h0100, 32'h0, 32'h1, 32'h10};
        vt[8]  = '{12'h004, 3'b001, 4'b0001, 16'h0000, 32'h24, 32'h8000_0000, 32'h0800_0000};
        vt[9]  = '{12'h002, 3'b100, 4'b0001, 16'h0100, 32'h0, 32'h8000_0000, 32'hF800_0000};
        vt[10] = '{12'h001, 3'b000, 4'b1000, 16'h1234, 32'h0, 32'h0, 32'h1234_0000};
        vt[11] = '{12'h800, 3'b010, 4'b0100, 16'h0000, 32'h0, 32'h0, PC0 + 32'd8};
        vt[12] = '{12'h000, 3'b001, 4'b0001, 16'h0000, 32'd5, 32'd7, 32'h0};
        vt[13] = '{12'h800, 3'b000, 4'b0000, 16'h0000, 32'd5, 32'd7, 32'h0};
        repeat (2) @(negedge clk);
        check("rst_mem", mem_bus, 76'h0);
        check("rst_id", id_fwd, 38'h0);
        check("rst_sram", {sen, swen, saddr, swdata}, 69'h0);
        check("rst_stallreq", sreq, 1'b0);
        rst = 1'b0;
        tick(mfhi, 6'b0);
        check("rst_hi", id_fwd[31:0], 32'h0);
        tick(mflo, 6'b0);
        check("rst_lo", id_fwd[31:0], 32'h0);
        tick(mk(PC0, {6'h09, 5'd1, 5'd5, 16'h0001}, 12'h800, 3'b001, 4'b0010, 1'b0, 4'h0, 1'b1, 5'd5,
                32'h7FFF_FFFF, 32'h0), 6'b0);
        check("addiu_res", mem_bus[31:0], 32'h8000_0000);
        check("addiu_fwd", id_fwd, {1'b1, 5'd5, 32'h8000_0000});
        for (int i = 0; i < 14; i++) begin
            tick(mk(PC0, {6'h3F, 5'd1, 5'd2, vt[i].imm}, vt[i].op, vt[i].s1, vt[i].s2, 1'b0, 4'h0, 1'b1, 5'd3,
                    vt[i].a, vt[i].b), 6'b0);
            check($sformatf("alu%0d", i), mem_bus[31:0], vt[i].exp);
        end
        tick(mk(PC0, {6'h2B, 5'd1, 5'd2, 16'hFFFC}, 12'h800, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0,
                32'h100, 32'hDEAD_BEEF), 6'b0);
        check("store_sram", {sen, swen, saddr, swdata}, {1'b1, 4'hF, 32'h0000_00FC, 32'hDEAD_BEEF});
        tick(mk(PC0, rtype(5'd1, 5'd0, 5'd0, 6'h11), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 32'hAAAA_0001, 32'h0), 6'b0);
        tick(mk(PC0, rtype(5'd1, 5'd0, 5'd0, 6'h13), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 32'h0000_5555, 32'h0), 6'b0);
        tick(mfhi, 6'b0);
        check("mthi", id_fwd[31:0], 32'hAAAA_0001);
        tick(mflo, 6'b0);
        check("mtlo", id_fwd[31:0], 32'h0000_5555);
        run_div(mk(PC0, rtype(5'd1, 5'd2, 5'd0, 6'h1A), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0,
                   32'hFFFF_FFF9, 32'd2), mflo, n);
        check("div_stall_cycles", n, 33);
        check("div_lo", id_fwd[31:0], 32'hFFFF_FFFD);
        tick(mfhi, 6'b0);
        check("div_hi", id_fwd[31:0], 32'hFFFF_FFFF);
        run_div(mk(PC0, rtype(5'd1, 5'd2, 5'd0, 6'h1B), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0,
                   32'd100, 32'd0), mflo, n);
        check("divu0_stall_cycles", n, 33);
        check("divu0_lo", id_fwd[31:0], 32'hFFFF_FFFF);
        tick(mfhi, 6'b0);
        check("divu0_hi", id_fwd[31:0], 32'd100);
        run_div(mk(PC0, rtype(5'd1, 5'd2, 5'd0, 6'h1A), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0,
                   32'd100, 32'hFFFF_FFF9), mflo, n);
        check("div_neg_lo", id_fwd[31:0], 32'hFFFF_FFF2);
        tick(mfhi, 6'b0);
        check("div_neg_hi", id_fwd[31:0], 32'd2);
        tick(mk(PC0, rtype(5'd1, 5'd2, 5'd0, 6'h1A), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 32'd1000, 32'd3), 6'b0);
        repeat (11) tick(id_bus, 6'b001111);
        check("div_busy", sreq, 1'b1);
        rst = 1'b1;
        tick('0, 6'b0);
        rst = 1'b0;
        check("div_rst_stallreq", sreq, 1'b0);
        tick(mfhi, 6'b0);
        check("div_rst_hi", id_fwd[31:0], 32'h0);
        tick(mflo, 6'b0);
        check("div_rst_lo", id_fwd[31:0], 32'h0);
        tick(mk(PC0, {6'h09, 5'd1, 5'd6, 16'h0010}, 12'h800, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd6, 32'h20, 32'h0), 6'b0);
        tick(mk(PC0, {6'h09, 5'd1, 5'd7, 16'h0001}, 12'h800, 3'b001, 4'b0010, 1'b0, 4'h0, 1'b1, 5'd7, 32'h1, 32'h0), 6'b001100);
        check("hold_res", id_fwd, {1'b1, 5'd6, 32'h30});
        tick(id_bus, 6'b000100);
        check("bubble_rf_we", mem_bus[37], 1'b0);
        check("bubble_ram_en", mem_bus[43], 1'b0);
        check("bubble_bus", mem_bus, 76'h0);
        tick(mk(PC0, rtype(5'd1, 5'd0, 5'd0, 6'h13), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 32'h77, 32'h0), 6'b0);
        tick(mk(PC0, rtype(5'd1, 5'd2, 5'd0, 6'h18), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0,
                32'hFFFF_FFFD, 32'd5), 6'b0);
        check("mult_res", id_fwd[31:0], 32'h0);
        tick(mfhi, 6'b0);
`ifdef EX_MULT_EN
        check("mult_hi", id_fwd[31:0], 32'hFFFF_FFFF);
        tick(mflo, 6'b0);
        check("mult_lo", id_fwd[31:0], 32'hFFFF_FFF1);
`else
        check("mult_hi", id_fwd[31:0], 32'h0);
        tick(mflo, 6'b0);
        check("mult_lo", id_fwd[31:0], 32'h77);
`endif
        tick('0, 6'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
